// File: rtl/imm_gen_stage_pkg.sv
// Shared encodings for the immediate-generation stage: immediate format
// codes and the RV32I/RV64I major opcodes the decoder recognises.
package imm_gen_stage_pkg;

   // Immediate format codes carried on out_imm_type
   localparam logic [2:0] IMM_NONE = 3'd0;
   localparam logic [2:0] IMM_I    = 3'd1;
   localparam logic [2:0] IMM_S    = 3'd2;
   localparam logic [2:0] IMM_B    = 3'd3;
   localparam logic [2:0] IMM_U    = 3'd4;
   localparam logic [2:0] IMM_J    = 3'd5;
   localparam logic [2:0] IMM_Z    = 3'd6;

   // Major opcodes (inst[6:0])
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_FENCE    = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_OP32     = 7'b0111011;

   // Decoder result bundle: format plus legality
   typedef struct packed {
      logic [2:0] imm_type;
      logic       illegal;
   } imm_class_t;

endpackage

// File: rtl/imm_gen_stage_decode.sv
// Combinational immediate decoder: classifies the opcode into an immediate
// format and builds the XLEN-wide immediate (sign-extended from inst[31],
// except the CSR zimm which is zero-extended).
module imm_decode
   import imm_gen_stage_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit RV64_OPS = 1'b0
) (
   input  logic [31:0]     i_inst,
   output logic [2:0]      o_imm_type,
   output logic [XLEN-1:0] o_imm,
   output logic            o_illegal
);

   imm_class_t  w_class;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [31:0] w_imm_b;
   logic [31:0] w_imm_u;
   logic [31:0] w_imm_j;

   // Raw 32-bit immediates, already sign-extended to 32 bits
   assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
   assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
   assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
   assign w_imm_u = {i_inst[31:12], 12'b0};
   assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

   // Opcode classification; anything unlisted (incl. inst[1:0]!=11) is illegal
   always_comb begin
      w_class.imm_type = IMM_NONE;
      w_class.illegal  = 1'b0;
      case (i_inst[6:0])
         OPC_OP_IMM, OPC_LOAD, OPC_JALR: w_class.imm_type = IMM_I;
         OPC_STORE:                      w_class.imm_type = IMM_S;
         OPC_BRANCH:                     w_class.imm_type = IMM_B;
         OPC_LUI, OPC_AUIPC:             w_class.imm_type = IMM_U;
         OPC_JAL:                        w_class.imm_type = IMM_J;
         OPC_SYSTEM:                     w_class.imm_type = i_inst[14] ? IMM_Z : IMM_I;
         OPC_OP, OPC_FENCE:              w_class.imm_type = IMM_NONE;
         OPC_OP_IMM32: begin
            if (RV64_OPS) w_class.imm_type = IMM_I;
            else          w_class.illegal  = 1'b1;
         end
         OPC_OP32: begin
            if (!RV64_OPS) w_class.illegal = 1'b1;
         end
         default:                        w_class.illegal  = 1'b1;
      endcase
   end

   // Select and widen the immediate for the decoded format
   always_comb begin
      o_imm = '0;
      case (w_class.imm_type)
         IMM_I:   o_imm = XLEN'($signed(w_imm_i));
         IMM_S:   o_imm = XLEN'($signed(w_imm_s));
         IMM_B:   o_imm = XLEN'($signed(w_imm_b));
         IMM_U:   o_imm = XLEN'($signed(w_imm_u));
         IMM_J:   o_imm = XLEN'($signed(w_imm_j));
         IMM_Z:   o_imm = XLEN'(i_inst[19:15]);
         default: o_imm = '0;
      endcase
   end

   assign o_imm_type = w_class.imm_type;
   assign o_illegal  = w_class.illegal;

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined immediate-generation stage between IFU and register read.
// One-cycle latency, full throughput, and a skid entry so that
// back-pressure never drops or duplicates an instruction.
//
// Handshake: a transfer happens on a clock edge where valid & ready are both
// high. in_valid/in_inst/in_pc must stay stable while in_valid & ~in_ready;
// out_* data is held stable while out_valid & ~out_ready. in_ready depends
// only on registered state (skid empty), never on out_ready combinationally.
// flush kills both entries and any same-cycle input.
module imm_gen_stage
   import imm_gen_stage_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit RV64_OPS = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_inst,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_imm_type,
   output logic            out_illegal
);

   logic [2:0]      w_dec_type;
   logic [XLEN-1:0] w_dec_imm;
   logic            w_dec_illegal;
   logic            w_accept;
   logic            w_main_free;

   // Main (output) entry
   logic            r_out_valid;
   logic [31:0]     r_out_inst;
   logic [XLEN-1:0] r_out_pc;
   logic [XLEN-1:0] r_out_imm;
   logic [2:0]      r_out_type;
   logic            r_out_illegal;

   // Skid entry
   logic            r_skid_valid;
   logic [31:0]     r_skid_inst;
   logic [XLEN-1:0] r_skid_pc;
   logic [XLEN-1:0] r_skid_imm;
   logic [2:0]      r_skid_type;
   logic            r_skid_illegal;

   imm_decode #(
      .XLEN     (XLEN),
      .RV64_OPS (RV64_OPS)
   ) u_decode (
      .i_inst     (in_inst),
      .o_imm_type (w_dec_type),
      .o_imm      (w_dec_imm),
      .o_illegal  (w_dec_illegal)
   );

   assign in_ready    = ~r_skid_valid;
   assign w_accept    = in_valid & in_ready & ~flush;
   assign w_main_free = ~r_out_valid | out_ready;

   // Main/skid sequencing: drain skid first to keep FIFO order
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid    <= 1'b0;
         r_out_inst     <= '0;
         r_out_pc       <= '0;
         r_out_imm      <= '0;
         r_out_type     <= IMM_NONE;
         r_out_illegal  <= 1'b0;
         r_skid_valid   <= 1'b0;
         r_skid_inst    <= '0;
         r_skid_pc      <= '0;
         r_skid_imm     <= '0;
         r_skid_type    <= IMM_NONE;
         r_skid_illegal <= 1'b0;
      end else if (flush) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_main_free) begin
         if (r_skid_valid) begin
            // in_ready is low whenever skid is full, so no accept can coincide
            r_out_valid   <= 1'b1;
            r_out_inst    <= r_skid_inst;
            r_out_pc      <= r_skid_pc;
            r_out_imm     <= r_skid_imm;
            r_out_type    <= r_skid_type;
            r_out_illegal <= r_skid_illegal;
            r_skid_valid  <= 1'b0;
         end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_inst    <= in_inst;
            r_out_pc      <= in_pc;
            r_out_imm     <= w_dec_imm;
            r_out_type    <= w_dec_type;
            r_out_illegal <= w_dec_illegal;
         end else begin
            r_out_valid   <= 1'b0;
         end
      end else if (w_accept) begin
         r_skid_valid   <= 1'b1;
         r_skid_inst    <= in_inst;
         r_skid_pc      <= in_pc;
         r_skid_imm     <= w_dec_imm;
         r_skid_type    <= w_dec_type;
         r_skid_illegal <= w_dec_illegal;
      end
   end

   assign out_valid    = r_out_valid;
   assign out_inst     = r_out_inst;
   assign out_pc       = r_out_pc;
   assign out_imm      = r_out_imm;
   assign out_imm_type = r_out_type;
   assign out_illegal  = r_out_illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: decode vectors against an XLEN=32 and an
// XLEN=64/RV64_OPS instance, then back-pressure, flush and reset sequences.
module tb_imm_gen_stage;

   typedef struct {
      logic [31:0] inst;
      logic [2:0]  t32;
      logic [31:0] imm32;
      logic        ill32;
      logic [2:0]  t64;
      logic [63:0] imm64;
      logic        ill64;
   } vec_t;

   localparam int NV = 20;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_inst;
   logic [31:0] in_pc32;
   logic [63:0] in_pc64;

   logic        in_ready32, out_valid32, out_illegal32;
   logic [31:0] out_inst32, out_pc32, out_imm32;
   logic [2:0]  out_type32;

   logic        in_ready64, out_valid64, out_illegal64;
   logic [31:0] out_inst64;
   logic [63:0] out_pc64, out_imm64;
   logic [2:0]  out_type64;

   int n_tests;
   int n_fail;
   logic [31:0] exp_q[$];
   logic        mon_en;
   logic        last_acc;
   vec_t        vecs[NV];

   imm_gen_stage #(.XLEN(32), .RV64_OPS(1'b0)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst), .in_pc(in_pc32),
      .out_valid(out_valid32), .out_ready(out_ready), .out_inst(out_inst32),
      .out_pc(out_pc32), .out_imm(out_imm32), .out_imm_type(out_type32),
      .out_illegal(out_illegal32)
   );

   imm_gen_stage #(.XLEN(64), .RV64_OPS(1'b1)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst), .in_pc(in_pc64),
      .out_valid(out_valid64), .out_ready(out_ready), .out_inst(out_inst64),
      .out_pc(out_pc64), .out_imm(out_imm64), .out_imm_type(out_type64),
      .out_illegal(out_illegal64)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock: scoreboard at negedge, then settle #1 past posedge
   task automatic cyc();
      @(negedge clk);
      last_acc = in_valid & in_ready32 & ~flush;
      if (mon_en) begin
         if (out_valid32 && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL scb_extra: got 0x%0h expected nothing", out_inst32);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               if (out_inst32 !== e) begin
                  n_fail++;
                  $display("FAIL scb_order: got 0x%0h expected 0x%0h", out_inst32, e);
               end
            end
         end
         if (last_acc) exp_q.push_back(in_inst);
      end
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [31:0] inst,
                               input logic [2:0] t32, input logic [31:0] imm32, input logic ill32,
                               input logic [2:0] t64, input logic [63:0] imm64, input logic ill64);
      vec_t v;
      v.inst = inst; v.t32 = t32; v.imm32 = imm32; v.ill32 = ill32;
      v.t64 = t64; v.imm64 = imm64; v.ill64 = ill64;
      return v;
   endfunction

   initial begin
      int sent;
      n_tests = 0; n_fail = 0;
      mon_en = 1'b0; last_acc = 1'b0;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_inst = '0; in_pc32 = '0; in_pc64 = '0;

      vecs[0]  = mk(32'hFFF00093, 3'd1, 32'hFFFFFFFF, 0, 3'd1, 64'hFFFFFFFFFFFFFFFF, 0); // addi -1
      vecs[1]  = mk(32'hFE20AE23, 3'd2, 32'hFFFFFFFC, 0, 3'd2, 64'hFFFFFFFFFFFFFFFC, 0); // sw -4
      vecs[2]  = mk(32'hFFDFF06F, 3'd5, 32'hFFFFFFFC, 0, 3'd5, 64'hFFFFFFFFFFFFFFFC, 0); // jal -4
      vecs[3]  = mk(32'h123450B7, 3'd4, 32'h12345000, 0, 3'd4, 64'h0000000012345000, 0); // lui
      vecs[4]  = mk(32'h800000B7, 3'd4, 32'h80000000, 0, 3'd4, 64'hFFFFFFFF80000000, 0); // lui neg
      vecs[5]  = mk(32'h00000000, 3'd0, 32'h0,        1, 3'd0, 64'h0,                1); // zero word
      vecs[6]  = mk(32'h3400D073, 3'd6, 32'h1,        0, 3'd6, 64'h1,                0); // csrrwi
      vecs[7]  = mk(32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 0, 3'd3, 64'hFFFFFFFFFFFFFFFC, 0); // beq -4
      vecs[8]  = mk(32'h00000463, 3'd3, 32'h8,        0, 3'd3, 64'h8,                0); // beq +8
      vecs[9]  = mk(32'h34009073, 3'd1, 32'h340,      0, 3'd1, 64'h340,              0); // csrrw
      vecs[10] = mk(32'h00208033, 3'd0, 32'h0,        0, 3'd0, 64'h0,                0); // add
      vecs[11] = mk(32'h0000100F, 3'd0, 32'h0,        0, 3'd0, 64'h0,                0); // fence.i
      vecs[12] = mk(32'hFFF0009B, 3'd0, 32'h0,        1, 3'd1, 64'hFFFFFFFFFFFFFFFF, 0); // addiw
      vecs[13] = mk(32'h0020803B, 3'd0, 32'h0,        1, 3'd0, 64'h0,                0); // addw
      vecs[14] = mk(32'h00001097, 3'd4, 32'h1000,     0, 3'd4, 64'h1000,             0); // auipc
      vecs[15] = mk(32'h00000001, 3'd0, 32'h0,        1, 3'd0, 64'h0,                1); // compressed
      vecs[16] = mk(32'h7FF0A083, 3'd1, 32'h7FF,      0, 3'd1, 64'h7FF,              0); // lw +2047
      vecs[17] = mk(32'h800080E7, 3'd1, 32'hFFFFF800, 0, 3'd1, 64'hFFFFFFFFFFFFF800, 0); // jalr -2048
      vecs[18] = mk(32'h008000EF, 3'd5, 32'h8,        0, 3'd5, 64'h8,                0); // jal +8
      vecs[19] = mk(32'hFFFFF0B7, 3'd4, 32'hFFFFF000, 0, 3'd4, 64'hFFFFFFFFFFFFF000, 0); // lui all-ones

      // Reset state
      #12;
      chk("rst_out_valid", 64'(out_valid32), 64'h0);
      chk("rst_in_ready",  64'(in_ready32),  64'h1);
      chk("rst_out_inst",  64'(out_inst32),  64'h0);
      chk("rst_out_imm64", out_imm64,        64'h0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Table-driven decode, back-to-back with out_ready high
      for (int i = 0; i < NV; i++) begin
         in_valid = 1'b1;
         in_inst  = vecs[i].inst;
         in_pc32  = 32'h1000 + 32'(i * 4);
         in_pc64  = 64'h1_0000_0000 + 64'(i * 4);
         cyc();
         chk($sformatf("v%0d_valid32", i), 64'(out_valid32), 64'h1);
         chk($sformatf("v%0d_inst32", i),  64'(out_inst32),  64'(vecs[i].inst));
         chk($sformatf("v%0d_pc32", i),    64'(out_pc32),    64'h1000 + 64'(i * 4));
         chk($sformatf("v%0d_type32", i),  64'(out_type32),  64'(vecs[i].t32));
         chk($sformatf("v%0d_imm32", i),   64'(out_imm32),   64'(vecs[i].imm32));
         chk($sformatf("v%0d_ill32", i),   64'(out_illegal32), 64'(vecs[i].ill32));
         chk($sformatf("v%0d_valid64", i), 64'(out_valid64), 64'h1);
         chk($sformatf("v%0d_pc64", i),    out_pc64,         64'h1_0000_0000 + 64'(i * 4));
         chk($sformatf("v%0d_type64", i),  64'(out_type64),  64'(vecs[i].t64));
         chk($sformatf("v%0d_imm64", i),   out_imm64,        vecs[i].imm64);
         chk($sformatf("v%0d_ill64", i),   64'(out_illegal64), 64'(vecs[i].ill64));
      end
      in_valid = 1'b0;
      cyc();
      chk("drain_valid", 64'(out_valid32), 64'h0);

      // Back-pressure: A in main, B in skid, C held upstream
      mon_en = 1'b1;
      out_ready = 1'b0;
      in_valid = 1'b1; in_inst = 32'h00A00093; cyc();
      chk("bp_a_loaded", 64'(out_inst32), 64'h00A00093);
      chk("bp_ready_a",  64'(in_ready32), 64'h1);
      in_inst = 32'h00B00093; cyc();
      chk("bp_a_held1",  64'(out_inst32), 64'h00A00093);
      chk("bp_ready_b",  64'(in_ready32), 64'h0);
      in_inst = 32'h00C00093; cyc();
      chk("bp_a_held2",  64'(out_inst32), 64'h00A00093);
      chk("bp_imm_held", 64'(out_imm32),  64'hA);
      chk("bp_ready_c",  64'(in_ready32), 64'h0);
      out_ready = 1'b1; cyc();
      chk("bp_b_out",    64'(out_inst32), 64'h00B00093);
      chk("bp_ready_rel", 64'(in_ready32), 64'h1);
      cyc();
      chk("bp_c_out",    64'(out_inst32), 64'h00C00093);
      chk("bp_c_valid",  64'(out_valid32), 64'h1);
      in_valid = 1'b0; cyc();
      chk("bp_empty",    64'(out_valid32), 64'h0);
      chk("bp_q_empty",  64'(exp_q.size()), 64'h0);

      // Random burst of 20 instructions under random back-pressure
      sent = 0;
      for (int k = 0; k < 300 && sent < 20; k++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_inst   = 32'h00000013 | (32'(sent) << 20);
         out_ready = ($urandom_range(0, 1) == 1);
         cyc();
         if (last_acc) sent++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) cyc();
      chk("burst_sent",    64'(sent),          64'd20);
      chk("burst_q_empty", 64'(exp_q.size()),  64'h0);
      chk("burst_idle",    64'(out_valid32),   64'h0);
      mon_en = 1'b0;

      // Flush with main and skid full and an input offered
      out_ready = 1'b0;
      in_valid = 1'b1; in_inst = 32'h00100093; cyc();
      in_inst = 32'h00200093; cyc();
      chk("fl_full", 64'(in_ready32), 64'h0);
      flush = 1'b1; in_inst = 32'h00D00093; cyc();
      chk("fl_valid",    64'(out_valid32), 64'h0);
      chk("fl_in_ready", 64'(in_ready32),  64'h1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cyc();
      chk("fl_no_ghost1", 64'(out_valid32), 64'h0);
      cyc();
      chk("fl_no_ghost2", 64'(out_valid32), 64'h0);
      // Flush with an empty stage drops the same-cycle input
      flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00E00093; cyc();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_drop_in", 64'(out_valid32), 64'h0);
      cyc();
      chk("fl_drop_in2", 64'(out_valid32), 64'h0);

      // Asynchronous reset mid-transfer
      out_ready = 1'b0;
      in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc32 = 32'h4444; cyc();
      in_inst = 32'h00300093; cyc();
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid",    64'(out_valid32), 64'h0);
      chk("ar_inst",     64'(out_inst32),  64'h0);
      chk("ar_imm",      64'(out_imm32),   64'h0);
      chk("ar_pc",       64'(out_pc32),    64'h0);
      chk("ar_in_ready", 64'(in_ready32),  64'h1);
      in_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      out_ready = 1'b1;
      cyc();
      chk("ar_no_survivor", 64'(out_valid32), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
